// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone classic arbiter: round-robin per cyc frame,
// with a watchdog that errors out transfers the slave never terminates.
//
// state | meaning
// IDLE  | bus free; slave outputs held at 0, arbitration on cyc requests
// GNT0  | m0 owns the bus; slave side and terminations muxed to m0
// GNT1  | m1 owns the bus; slave side and terminations muxed to m1
module wb_arbiter2 #(
    parameter int DAT_WIDTH = 64,
    parameter int ADR_WIDTH = 64,
    parameter int SEL_WIDTH = DAT_WIDTH / 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 m0_cyc_i,
    input  logic                 m0_stb_i,
    input  logic                 m0_we_i,
    input  logic [SEL_WIDTH-1:0] m0_sel_i,
    input  logic [ADR_WIDTH-1:0] m0_adr_i,
    input  logic [DAT_WIDTH-1:0] m0_dat_i,
    output logic [DAT_WIDTH-1:0] m0_dat_o,
    output logic                 m0_ack_o,
    output logic                 m0_err_o,

    input  logic                 m1_cyc_i,
    input  logic                 m1_stb_i,
    input  logic                 m1_we_i,
    input  logic [SEL_WIDTH-1:0] m1_sel_i,
    input  logic [ADR_WIDTH-1:0] m1_adr_i,
    input  logic [DAT_WIDTH-1:0] m1_dat_i,
    output logic [DAT_WIDTH-1:0] m1_dat_o,
    output logic                 m1_ack_o,
    output logic                 m1_err_o,

    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    output logic                 s_we_o,
    output logic [SEL_WIDTH-1:0] s_sel_o,
    output logic [ADR_WIDTH-1:0] s_adr_o,
    output logic [DAT_WIDTH-1:0] s_dat_o,
    input  logic [DAT_WIDTH-1:0] s_dat_i,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,

    output logic [1:0]           grant_o,
    output logic                 timeout_o
);

    localparam bit WD_EN = (TIMEOUT > 0);
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    // Encoding doubles as the one-hot grant vector, so grant_o comes straight off flops.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t          state;
    logic            last;
    logic [WD_W-1:0] wd;
    logic            own_cyc;
    logic            term;
    logic            wd_fire;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign grant_o  = state;
    assign term     = s_ack_i | s_err_i;

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        own_cyc = 1'b0;
        case (state)
            GNT0: begin
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i;
                s_we_o  = m0_we_i;
                s_sel_o = m0_sel_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                own_cyc = m0_cyc_i;
            end
            GNT1: begin
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i;
                s_we_o  = m1_we_i;
                s_sel_o = m1_sel_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                own_cyc = m1_cyc_i;
            end
            default: ;
        endcase
    end

    // Fires in the TIMEOUT-th consecutive unterminated strobe cycle of a grant.
    assign wd_fire   = WD_EN && (state != IDLE) && s_stb_o && !term && (wd == WD_LAST);
    assign timeout_o = wd_fire;

    always_comb begin
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state)
            GNT0: begin
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | wd_fire;
            end
            GNT1: begin
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | wd_fire;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
            wd    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wd <= '0;
                    if (m0_cyc_i && (!m1_cyc_i || last)) begin
                        state <= GNT0;
                        last  <= 1'b0;
                    end else if (m1_cyc_i) begin
                        state <= GNT1;
                        last  <= 1'b1;
                    end
                end
                GNT0, GNT1: begin
                    if (wd_fire || !own_cyc)
                        state <= IDLE;
                    if (!WD_EN || wd_fire || !s_stb_o || term)
                        wd <= '0;
                    else
                        wd <= wd + WD_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed-vector bench for wb_arbiter2 (TIMEOUT=4): grant, handover,
// round-robin, watchdog, error passthrough and async reset.
module tb_wb_arbiter2;

    localparam int DW = 64;
    localparam int AW = 64;
    localparam int SW = DW / 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
    logic [SW-1:0] m0_sel_i = '0;
    logic [AW-1:0] m0_adr_i = '0;
    logic [DW-1:0] m0_dat_i = '0;
    logic [DW-1:0] m0_dat_o;
    logic          m0_ack_o, m0_err_o;
    logic          m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
    logic [SW-1:0] m1_sel_i = '0;
    logic [AW-1:0] m1_adr_i = '0;
    logic [DW-1:0] m1_dat_i = '0;
    logic [DW-1:0] m1_dat_o;
    logic          m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [SW-1:0] s_sel_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [DW-1:0] s_dat_i = '0;
    logic          s_ack_i = 0, s_err_i = 0;
    logic [1:0]    grant_o;
    logic          timeout_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    wb_arbiter2 #(.DAT_WIDTH(DW), .ADR_WIDTH(AW), .SEL_WIDTH(SW), .TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_masters();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        s_ack_i  = 0; s_err_i  = 0;
    endtask

    // Leaves time at posedge+3 with reset released.
    task automatic do_reset();
        rst_i = 1'b0;
        idle_masters();
        repeat (2) @(posedge clk_i);
        #3 rst_i = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got hung expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [1:0] seq [4];
        logic [1:0] prev;
        int         nrec;
        int         h0;
        int         h1;

        // Reset state
        s_dat_i = 64'h0000_0000_0000_1234;
        #12;
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_scyc", s_cyc_o, 1'b0);
        chk("rst_dat_follow", m0_dat_o, 64'h1234);
        chk("rst_timeout", timeout_o, 1'b0);
        do_reset();

        // Single master read, ack two cycles after stb
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0;
        m0_sel_i = 8'hFF; m0_adr_i = 64'h0000_8000_0000_0000;
        #1;
        chk("single_pre_scyc", s_cyc_o, 1'b0);
        tick();
        chk("single_grant", grant_o, 2'b01);
        chk("single_scyc", s_cyc_o, 1'b1);
        chk("single_adr", s_adr_o, 64'h0000_8000_0000_0000);
        chk("single_noack", m0_ack_o, 1'b0);
        tick();
        tick();
        s_ack_i = 1; s_dat_i = 64'hCAFE_F00D_1234_5678;
        #1;
        chk("single_ack", m0_ack_o, 1'b1);
        chk("single_rdat", m0_dat_o, 64'hCAFE_F00D_1234_5678);
        chk("single_m1_ack", m1_ack_o, 1'b0);
        chk("single_no_wd", timeout_o, 1'b0);
        tick();
        m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
        #1;
        chk("single_scyc_drop", s_cyc_o, 1'b0);
        tick();
        chk("single_grant_idle", grant_o, 2'b00);

        // Contention from reset
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0;
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1;
        m1_dat_i = 64'h0000_0000_DEAD_BEEF; m1_adr_i = 64'h40;
        tick();
        chk("cont_first_m0", grant_o, 2'b01);
        chk("cont_m0_we", s_we_o, 1'b0);
        m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        chk("cont_dead_cycle", grant_o, 2'b00);
        chk("cont_dead_scyc", s_cyc_o, 1'b0);
        tick();
        chk("cont_then_m1", grant_o, 2'b10);
        chk("cont_m1_dat", s_dat_o, 64'h0000_0000_DEAD_BEEF);
        chk("cont_m1_we", s_we_o, 1'b1);
        chk("cont_m1_adr", s_adr_o, 64'h40);
        idle_masters();
        tick();

        // Round-robin: each master holds cyc for 3 granted cycles per frame
        for (int k = 0; k < 4; k++) seq[k] = 2'b00;
        prev = 2'b00; nrec = 0; h0 = 0; h1 = 0;
        m0_cyc_i = 1; m1_cyc_i = 1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (grant_o != 2'b00 && grant_o != prev && nrec < 4) begin
                seq[nrec] = grant_o;
                nrec++;
            end
            prev = grant_o;
            if (grant_o == 2'b01 && m0_cyc_i) begin
                h0++;
                if (h0 == 3) begin m0_cyc_i = 0; h0 = 0; end
            end else if (!m0_cyc_i) m0_cyc_i = 1;
            if (grant_o == 2'b10 && m1_cyc_i) begin
                h1++;
                if (h1 == 3) begin m1_cyc_i = 0; h1 = 0; end
            end else if (!m1_cyc_i) m1_cyc_i = 1;
        end
        chk("rr_grant0", seq[0], 2'b01);
        chk("rr_grant1", seq[1], 2'b10);
        chk("rr_grant2", seq[2], 2'b01);
        chk("rr_grant3", seq[3], 2'b10);
        idle_masters();
        tick();
        tick();

        // Watchdog with m1 owning a hung slave, m0 pending
        do_reset();
        m1_cyc_i = 1; m1_stb_i = 1;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1;
        #1;
        chk("wd_c1_timeout", timeout_o, 1'b0);
        chk("wd_c1_grant", grant_o, 2'b10);
        tick();
        tick();
        chk("wd_c3_err", m1_err_o, 1'b0);
        chk("wd_c3_timeout", timeout_o, 1'b0);
        tick();
        chk("wd_c4_err", m1_err_o, 1'b1);
        chk("wd_c4_timeout", timeout_o, 1'b1);
        chk("wd_c4_m0_err", m0_err_o, 1'b0);
        tick();
        chk("wd_release_scyc", s_cyc_o, 1'b0);
        chk("wd_release_idle", grant_o, 2'b00);
        chk("wd_pulse_once", timeout_o, 1'b0);
        tick();
        chk("wd_pending_m0", grant_o, 2'b01);

        // Slave error passthrough, and the watchdog restarts from zero after it
        s_err_i = 1;
        #1;
        chk("serr_m0_err", m0_err_o, 1'b1);
        chk("serr_m1_err", m1_err_o, 1'b0);
        chk("serr_timeout", timeout_o, 1'b0);
        tick();
        s_err_i = 0;
        tick();
        tick();
        #1;
        chk("serr_wd_cleared", timeout_o, 1'b0);
        tick();
        chk("serr_wd_refire", timeout_o, 1'b1);
        chk("serr_wd_err", m0_err_o, 1'b1);
        tick();
        chk("serr_release_idle", grant_o, 2'b00);
        tick();
        chk("fair_m1_after_wd", grant_o, 2'b10);

        // Simultaneous ack and err pass through unresolved
        s_ack_i = 1; s_err_i = 1;
        #1;
        chk("both_ack", m1_ack_o, 1'b1);
        chk("both_err", m1_err_o, 1'b1);
        chk("both_m0_ack", m0_ack_o, 1'b0);
        idle_masters();
        tick();
        tick();

        // Async reset mid-transfer
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        chk("arst_pre_scyc", s_cyc_o, 1'b1);
        #2 rst_i = 1'b0;
        #1;
        chk("arst_scyc", s_cyc_o, 1'b0);
        chk("arst_sstb", s_stb_o, 1'b0);
        chk("arst_grant", grant_o, 2'b00);
        #2 rst_i = 1'b1;
        m1_cyc_i = 1;
        tick();
        chk("arst_first_m0", grant_o, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
